apb_xfer_arbiter: RTL and testbench
===================================

# apb_xfer_arbiter

Shares the single APB bus between the AXI4 bridge's write path and read path. Arbitrates between the two requesters with a round-robin policy and runs the APB SETUP/ACCESS sequence itself. Decodes the UART/TIMER slave select and bounds every access with a PREADY timeout. Sits between the AXI4 slave front end and the APB peripherals (UART, TIMER); it replaces direct per-channel driving of the APB master.

## Interface
- ADDR_WIDTH, 32, APB address width (≥4)
- DATA_WIDTH, 32, APB data width (strobe fixed at 4 bits)
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort (≥2)

Clocking and reset:
- PCLK  in  1  clock, all state on rising edge
- PRESET  in  1  reset, asynchronous, active-high

Write requester:
- wr_req  in  1  write request, level, hold until wr_done
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_strb  in  4  byte strobes
- wr_done  out  1  one-cycle completion pulse
- wr_err  out  1  valid with wr_done: PSLVERR or timeout

Read requester:
- rd_req  in  1  read request, level, hold until rd_done
- rd_addr  in  ADDR_WIDTH  read address
- rd_done  out  1  one-cycle completion pulse
- rd_err  out  1  valid with rd_done
- rd_data  out  DATA_WIDTH  read data, valid with rd_done, held until next read completes

APB bus:
- PSEL_UART, PSEL_TIMER  out  1 each  slave selects
- PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  4
- PRDATA  in  DATA_WIDTH; PREADY, PSLVERR  in  1 each
- busy  out  1  high in SETUP/ACCESS

## Operation
- States: IDLE, SETUP, ACCESS.
- IDLE: eligible requesters = those whose req is high and whose done is not asserted this cycle. No eligible requester: stay in IDLE.
- Arbitration: one eligible requester is granted. With two, grant the one not granted last; last_grant resets to READ, so write wins the first tie.
- On grant, capture addr/data/strb/direction into registers and go to SETUP. Requester inputs are don't-care after grant.
- SETUP: PSEL asserted, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from captured registers. PSTRB=0 for reads. Always → ACCESS.
- Slave decode: PADDR[ADDR_WIDTH-1:ADDR_WIDTH-4]==0 → PSEL_UART, else PSEL_TIMER. Exactly one select is high in SETUP/ACCESS.
- ACCESS: PENABLE=1, the timeout counter increments each cycle with PREADY low.
- PREADY=1: complete. Done pulses next cycle and err=PSLVERR. For reads, rd_data←PRDATA, also on error. → IDLE.
- Timeout: counter reaches TIMEOUT-1 with PREADY low → abort, done=1, err=1, rd_data←0, → IDLE.
- APB address/data/control stay stable from SETUP through the end of ACCESS.
- In IDLE, PSEL*, PENABLE and PSTRB are 0. PADDR/PWDATA/PWRITE hold their last values.
- Counter width is $clog2(TIMEOUT+1). It clears on entry to SETUP.

## Timing
- Reset (async): state=IDLE, last_grant=READ, counter=0. Every output is 0, including rd_data, PADDR and PWDATA.
- PRESET asserted mid-transfer: PSEL/PENABLE drop immediately, the transaction is discarded and no done is issued.
- All outputs are registered. No combinational path from PREADY/PRDATA to any output.
- Latency, zero-wait slave: req high at cycle 0 → SETUP at 1 → ACCESS at 2 → done at 3. Each PREADY wait state adds 1.
- Back-to-back: the other requester can be granted in the done cycle (state is IDLE), so its SETUP is at cycle 4. There is one IDLE cycle between transfers.
- A requester whose done is high in cycle N may re-request from N+1 and is eligible then.
- Timeout with PREADY never high: done at cycle 2+TIMEOUT.

## Structure
- Package apb_pkg holds:
  - state enum (IDLE/SETUP/ACCESS)
  - requester id constants (REQ_WR, REQ_RD)
  - UART_REGION=4'h0
  - decode function region→{sel_uart, sel_timer}
- Sub-module apb_rr_arb2: 2-way round-robin arbiter with inputs req[1:0], advance, and outputs gnt[1:0] one-hot, holding last_grant. Everything else is in apb_xfer_arbiter.

## Test plan
- Single write: wr_addr=0x0000_0010, wr_data=0xA5A5_A5A5, wr_strb=0xF, PREADY tied 1 → PSEL_UART SETUP at cycle 1, PENABLE at 2, wr_done=1 and wr_err=0 at 3.
- Read with waits: rd_addr=0x1000_0004, PREADY low 3 cycles, PRDATA=0x1234_5678 → PSEL_TIMER, PSTRB=0, rd_done at cycle 6, rd_data=0x1234_5678.
- Contention: wr_req and rd_req both held from reset → grants alternate W,R,W,R. Each done is followed by the other requester's SETUP one cycle later.
- Slave error: write with PSLVERR=1 at PREADY → wr_done with wr_err=1, and the next transfer is unaffected.
- Timeout: TIMEOUT=4, read, PREADY stuck 0 → PSEL/PENABLE drop, rd_done and rd_err=1, rd_data=0 at cycle 6.
- Reset mid-ACCESS: assert PRESET during ACCESS → all outputs 0 asynchronously, no done. After release, a pending wr_req is granted normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB transfer arbiter: FSM states,
// requester ids and the UART/TIMER slave-select decode.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic REQ_WR = 1'b0;
  localparam logic REQ_RD = 1'b1;

  localparam logic [3:0] UART_REGION = 4'h0;

  // Returns {sel_uart, sel_timer}; exactly one bit is ever set.
  function automatic logic [1:0] decode_sel(input logic [3:0] region);
    return (region == UART_REGION) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
// last_grant only moves when the grant is actually taken (advance).
module apb_rr_arb2
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic lastGrant_q;
  logic lastGrant_d;

  always_comb begin
    gnt         = 2'b00;
    lastGrant_d = lastGrant_q;
    if (req[REQ_WR] && req[REQ_RD]) begin
      if (lastGrant_q == REQ_RD) begin
        gnt[REQ_WR] = 1'b1;
      end else begin
        gnt[REQ_RD] = 1'b1;
      end
    end else begin
      gnt = req;
    end
    if (advance && gnt[REQ_WR]) begin
      lastGrant_d = REQ_WR;
    end else if (advance && gnt[REQ_RD]) begin
      lastGrant_d = REQ_RD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant_q <= REQ_RD;
    end else begin
      lastGrant_q <= lastGrant_d;
    end
  end

endmodule

// File: rtl/apb_xfer_arbiter.sv
// Shares one APB master between the AXI bridge write and read paths, runs the
// SETUP/ACCESS handshake and bounds each access with a PREADY timeout.
module apb_xfer_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [3:0]            wr_strb,
  output logic                  wr_done,
  output logic                  wr_err,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  PSEL_UART,
  output logic                  PSEL_TIMER,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic                  busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic                  pwrite_q, pwrite_d;
  logic                  pselUart_q, pselUart_d;
  logic                  pselTimer_q, pselTimer_d;
  logic                  penable_q, penable_d;
  logic                  busy_q, busy_d;
  logic                  wrDone_q, wrDone_d;
  logic                  wrErr_q, wrErr_d;
  logic                  rdDone_q, rdDone_d;
  logic                  rdErr_q, rdErr_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;

  logic [1:0]            arbReq;
  logic [1:0]            gnt;
  logic                  inIdle;
  logic                  finish;
  logic                  errVal;
  logic [DATA_WIDTH-1:0] rdVal;
  logic [1:0]            sel;

  // A requester whose done pulse is showing this cycle is not yet eligible.
  assign inIdle             = (state_q == IDLE);
  assign arbReq[REQ_WR]     = inIdle && wr_req && !wrDone_q;
  assign arbReq[REQ_RD]     = inIdle && rd_req && !rdDone_q;

  apb_rr_arb2 u_arb (
    .clk     (PCLK),
    .rst     (PRESET),
    .req     (arbReq),
    .advance (inIdle && (gnt != 2'b00)),
    .gnt     (gnt)
  );

  // Every output is computed from the next state and then registered, so
  // PREADY/PRDATA never reach a pin combinationally.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pstrb_d  = pstrb_q;
    pwrite_d = pwrite_q;
    finish   = 1'b0;
    errVal   = 1'b0;
    rdVal    = '0;
    case (state_q)
      IDLE: begin
        if (gnt[REQ_WR]) begin
          state_d  = SETUP;
          cnt_d    = '0;
          pwrite_d = 1'b1;
          paddr_d  = wr_addr;
          pwdata_d = wr_data;
          pstrb_d  = wr_strb;
        end else if (gnt[REQ_RD]) begin
          state_d  = SETUP;
          cnt_d    = '0;
          pwrite_d = 1'b0;
          paddr_d  = rd_addr;
          pstrb_d  = 4'h0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d = IDLE;
          finish  = 1'b1;
          errVal  = PSLVERR;
          rdVal   = PRDATA;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          finish  = 1'b1;
          errVal  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == IDLE) begin
      pstrb_d = 4'h0;
    end
    sel         = decode_sel(paddr_d[ADDR_WIDTH-1 -: 4]);
    busy_d      = (state_d != IDLE);
    pselUart_d  = busy_d && sel[1];
    pselTimer_d = busy_d && sel[0];
    penable_d   = (state_d == ACCESS);
    wrDone_d    = finish && pwrite_q;
    wrErr_d     = finish && pwrite_q && errVal;
    rdDone_d    = finish && !pwrite_q;
    rdErr_d     = finish && !pwrite_q && errVal;
    rdData_d    = (finish && !pwrite_q) ? rdVal : rdData_q;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pwrite_q    <= 1'b0;
      pselUart_q  <= 1'b0;
      pselTimer_q <= 1'b0;
      penable_q   <= 1'b0;
      busy_q      <= 1'b0;
      wrDone_q    <= 1'b0;
      wrErr_q     <= 1'b0;
      rdDone_q    <= 1'b0;
      rdErr_q     <= 1'b0;
      rdData_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pwrite_q    <= pwrite_d;
      pselUart_q  <= pselUart_d;
      pselTimer_q <= pselTimer_d;
      penable_q   <= penable_d;
      busy_q      <= busy_d;
      wrDone_q    <= wrDone_d;
      wrErr_q     <= wrErr_d;
      rdDone_q    <= rdDone_d;
      rdErr_q     <= rdErr_d;
      rdData_q    <= rdData_d;
    end
  end

  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign PWRITE     = pwrite_q;
  assign PSEL_UART  = pselUart_q;
  assign PSEL_TIMER = pselTimer_q;
  assign PENABLE    = penable_q;
  assign busy       = busy_q;
  assign wr_done    = wrDone_q;
  assign wr_err     = wrErr_q;
  assign rd_done    = rdDone_q;
  assign rd_err     = rdErr_q;
  assign rd_data    = rdData_q;

endmodule

// File: tb/tb_apb_xfer_arbiter.sv
// Directed bench for apb_xfer_arbiter (TIMEOUT=4): single write, waited read,
// contention, slave error, timeout and reset in the middle of ACCESS.
module tb_apb_xfer_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_done;
  logic        wr_err;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_done;
  logic        rd_err;
  logic [31:0] rd_data;
  logic        PSEL_UART;
  logic        PSEL_TIMER;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        busy;

  int passCount = 0;
  int totalCount = 0;

  apb_xfer_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .wr_done    (wr_done),
    .wr_err     (wr_err),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_done    (rd_done),
    .rd_err     (rd_err),
    .rd_data    (rd_data),
    .PSEL_UART  (PSEL_UART),
    .PSEL_TIMER (PSEL_TIMER),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .busy       (busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic wr, input logic rd,
                               input logic ready, input logic slverr);
    wr_req  = wr;
    rd_req  = rd;
    PREADY  = ready;
    PSLVERR = slverr;
  endtask

  initial begin
    PRESET  = 1'b1;
    wr_req  = 1'b0;
    rd_req  = 1'b0;
    wr_addr = 32'h0000_0010;
    wr_data = 32'hA5A5_A5A5;
    wr_strb = 4'hF;
    rd_addr = 32'h1000_0004;
    PRDATA  = 32'h0;
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    #1;
    checkOutput("rst_psel_uart", PSEL_UART, 0);
    checkOutput("rst_psel_timer", PSEL_TIMER, 0);
    checkOutput("rst_penable", PENABLE, 0);
    checkOutput("rst_paddr", PADDR, 0);
    checkOutput("rst_pwdata", PWDATA, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_busy", busy, 0);
    tick(2);
    PRESET = 1'b0;

    // Single write to UART, zero-wait slave
    applyStimulus(1, 0, 1, 0);
    tick();
    checkOutput("w_c1_psel_uart", PSEL_UART, 1);
    checkOutput("w_c1_psel_timer", PSEL_TIMER, 0);
    checkOutput("w_c1_penable", PENABLE, 0);
    checkOutput("w_c1_paddr", PADDR, 32'h0000_0010);
    checkOutput("w_c1_pwdata", PWDATA, 32'hA5A5_A5A5);
    checkOutput("w_c1_pstrb", PSTRB, 4'hF);
    checkOutput("w_c1_pwrite", PWRITE, 1);
    checkOutput("w_c1_busy", busy, 1);
    tick();
    checkOutput("w_c2_penable", PENABLE, 1);
    checkOutput("w_c2_wr_done", wr_done, 0);
    tick();
    checkOutput("w_c3_wr_done", wr_done, 1);
    checkOutput("w_c3_wr_err", wr_err, 0);
    checkOutput("w_c3_psel_uart", PSEL_UART, 0);
    checkOutput("w_c3_pstrb", PSTRB, 0);
    checkOutput("w_c3_paddr_hold", PADDR, 32'h0000_0010);
    applyStimulus(0, 0, 1, 0);
    tick();
    checkOutput("w_c4_wr_done", wr_done, 0);

    // Read from TIMER with three wait states
    PRDATA = 32'h1234_5678;
    applyStimulus(0, 1, 0, 0);
    tick();
    checkOutput("r_c1_psel_timer", PSEL_TIMER, 1);
    checkOutput("r_c1_psel_uart", PSEL_UART, 0);
    checkOutput("r_c1_pstrb", PSTRB, 0);
    checkOutput("r_c1_pwrite", PWRITE, 0);
    checkOutput("r_c1_paddr", PADDR, 32'h1000_0004);
    tick(4);
    checkOutput("r_c5_penable", PENABLE, 1);
    checkOutput("r_c5_rd_done", rd_done, 0);
    PREADY = 1'b1;
    tick();
    checkOutput("r_c6_rd_done", rd_done, 1);
    checkOutput("r_c6_rd_err", rd_err, 0);
    checkOutput("r_c6_rd_data", rd_data, 32'h1234_5678);
    checkOutput("r_c6_penable", PENABLE, 0);
    rd_req = 1'b0;
    PRDATA = 32'hDEAD_BEEF;
    tick();
    checkOutput("r_c7_rd_data_hold", rd_data, 32'h1234_5678);

    // Contention from reset: grants alternate W, R, W, R
    PRESET = 1'b1;
    tick();
    applyStimulus(1, 1, 1, 0);
    PRESET = 1'b0;
    tick();
    checkOutput("c_c1_pwrite", PWRITE, 1);
    checkOutput("c_c1_psel_uart", PSEL_UART, 1);
    tick(2);
    checkOutput("c_c3_wr_done", wr_done, 1);
    checkOutput("c_c3_busy", busy, 0);
    tick();
    checkOutput("c_c4_psel_timer", PSEL_TIMER, 1);
    checkOutput("c_c4_pwrite", PWRITE, 0);
    tick(2);
    checkOutput("c_c6_rd_done", rd_done, 1);
    checkOutput("c_c6_rd_data", rd_data, 32'hDEAD_BEEF);
    tick();
    checkOutput("c_c7_pwrite", PWRITE, 1);
    checkOutput("c_c7_psel_uart", PSEL_UART, 1);
    tick(3);
    checkOutput("c_c10_pwrite", PWRITE, 0);
    checkOutput("c_c10_psel_timer", PSEL_TIMER, 1);
    applyStimulus(0, 0, 1, 0);
    tick(2);
    checkOutput("c_c12_rd_done", rd_done, 1);
    tick();

    // Slave error on a write, then a clean read right behind it
    wr_data = 32'h0000_00FF;
    wr_strb = 4'h3;
    applyStimulus(1, 0, 1, 1);
    tick();
    checkOutput("e_c1_pstrb", PSTRB, 4'h3);
    tick(2);
    checkOutput("e_c3_wr_done", wr_done, 1);
    checkOutput("e_c3_wr_err", wr_err, 1);
    PRDATA = 32'hCAFE_F00D;
    applyStimulus(0, 1, 1, 0);
    tick();
    checkOutput("e_c4_wr_err", wr_err, 0);
    checkOutput("e_c4_psel_timer", PSEL_TIMER, 1);
    tick(2);
    checkOutput("e_c6_rd_done", rd_done, 1);
    checkOutput("e_c6_rd_err", rd_err, 0);
    checkOutput("e_c6_rd_data", rd_data, 32'hCAFE_F00D);
    rd_req = 1'b0;
    tick();

    // Timeout: PREADY stuck low, TIMEOUT=4 gives done at cycle 6
    applyStimulus(0, 1, 0, 0);
    tick(5);
    checkOutput("t_c5_penable", PENABLE, 1);
    checkOutput("t_c5_rd_done", rd_done, 0);
    tick();
    checkOutput("t_c6_rd_done", rd_done, 1);
    checkOutput("t_c6_rd_err", rd_err, 1);
    checkOutput("t_c6_rd_data", rd_data, 0);
    checkOutput("t_c6_psel_timer", PSEL_TIMER, 0);
    checkOutput("t_c6_penable", PENABLE, 0);
    rd_req = 1'b0;
    tick();

    // Reset in the middle of ACCESS, then a pending write proceeds normally
    applyStimulus(1, 0, 0, 0);
    tick(2);
    checkOutput("x_c2_penable", PENABLE, 1);
    #2;
    PRESET = 1'b1;
    #1;
    checkOutput("x_rst_psel_uart", PSEL_UART, 0);
    checkOutput("x_rst_penable", PENABLE, 0);
    checkOutput("x_rst_paddr", PADDR, 0);
    checkOutput("x_rst_pwrite", PWRITE, 0);
    checkOutput("x_rst_busy", busy, 0);
    tick();
    checkOutput("x_rst_wr_done", wr_done, 0);
    PREADY = 1'b1;
    PRESET = 1'b0;
    tick();
    checkOutput("x_c1_psel_uart", PSEL_UART, 1);
    checkOutput("x_c1_wr_done", wr_done, 0);
    checkOutput("x_c1_pwdata", PWDATA, 32'h0000_00FF);
    tick(2);
    checkOutput("x_c3_wr_done", wr_done, 1);
    checkOutput("x_c3_wr_err", wr_err, 0);
    wr_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
